// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Program-counter and fetch sequencer that sits in front of an 8-bit
// instruction ROM. It drives the ROM address, examines the returned
// instruction word for HALT, applies relative branches resolved by the
// datapath, and counts retired instructions.
//
// Ports
//   clk           in   system clock, all state updates on the rising edge
//   reset         in   synchronous, active-high reset
//   start_i       in   one-cycle request to begin a program (IDLE/HALTED only)
//   start_addr_i  in   entry address, latched together with start_i
//   inst_i        in   instruction word the ROM returns for pc_o (same cycle)
//   stall_i       in   hold the PC this cycle
//   branch_i      in   taken branch for the instruction at pc_o
//   branch_back_i in   1 = backward (pc - offset), 0 = forward (pc + offset)
//   offset_i      in   unsigned branch distance
//   pc_o          out  ROM address (registered)
//   running_o     out  high while the program is running
//   done_o        out  high once HALT has been fetched
//   retired_o     out  instructions retired since the last accepted start,
//                      saturating at all-ones
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter logic [7:0]  HALT_OP = 8'b10001000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [PC_W-1:0]  start_addr_i,
    input  logic [7:0]       inst_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             branch_back_i,
    input  logic [PC_W-1:0]  offset_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             running_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [PC_W-1:0]  pc_q,      pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             running_q, running_d;
    logic             done_q,    done_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    logic [CNT_W-1:0] retired_inc;
    assign retired_inc = (retired_q == {CNT_W{1'b1}}) ? retired_q
                                                       : retired_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                // inst_i is ignored outside RUN, so a start always wins here.
                if (start_i) begin
                    state_d   = S_RUN;
                    pc_d      = start_addr_i;
                    retired_d = '0;
                end
            end

            S_RUN: begin
                // Priority: halt > stall > branch > sequential increment.
                if (inst_i == HALT_OP) begin
                    // PC freezes on the halt address; the halt itself retires.
                    state_d   = S_HALTED;
                    retired_d = retired_inc;
                end else if (stall_i) begin
                    // Hold everything; a branch under stall is dropped and
                    // must be re-asserted by the datapath.
                end else if (branch_i) begin
                    // Modulo-2^PC_W arithmetic; wrap-around is silent.
                    pc_d      = branch_back_i ? (pc_q - offset_i)
                                              : (pc_q + offset_i);
                    retired_d = retired_inc;
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    retired_d = retired_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so that, once
        // registered, they track state_q exactly and never see raw inputs.
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc_o      = pc_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign retired_o = retired_q;

endmodule
